// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh terminal receive endpoint: header layout,
// payload geometry helper and the receive FSM state encoding.
package mesh_pkg;

  localparam int unsigned NXT_W  = 8;
  localparam int unsigned ROW_W  = 4;
  localparam int unsigned COL_W  = 4;
  localparam int unsigned MODE_W = 1;
  localparam int unsigned HDR_W  = NXT_W + ROW_W + COL_W + MODE_W;
  localparam int unsigned DEST_W = ROW_W + COL_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2
  } rx_state_e;

  // Header occupies the top HDR_W bits of every packet, MSB first.
  typedef struct packed {
    logic [NXT_W-1:0]  nxt_jmp;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [MODE_W-1:0] mode;
  } pkt_hdr_t;

  // Payload width (and header LSB offset) for a packet of sz bits.
  function automatic int unsigned pay_w(input int unsigned sz);
    return sz - HDR_W;
  endfunction

endpackage

// File: rtl/mesh_term_fifo.sv
// Synchronous payload FIFO for mesh_term_rx; power-of-two depth with
// wrap-bit pointers and a registered empty flag.
module mesh_term_fifo #(
  parameter int unsigned width = 24,
  parameter int unsigned depth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  input  logic             rd_en,
  output logic [width-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(depth);

  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic [width-1:0] mem [depth];
  logic             wr_ok, rd_ok;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_ok    = wr_en & ~full;
  assign rd_ok    = rd_en & ~empty;
  assign wr_ptr_d = wr_ptr + (AW+1)'(wr_ok);
  assign rd_ptr_d = rd_ptr + (AW+1)'(rd_ok);
  assign rd_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      empty  <= (wr_ptr_d == rd_ptr_d);
    end
  end

  // Storage is reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < depth; i++) mem[AW'(i)] <= '0;
    end else if (wr_ok) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/mesh_term_rx.sv
// Receive endpoint for one mesh_gnrtr terminal: pops router packets, keeps
// local/broadcast payloads in a FIFO. Optional counters: MESH_TERM_RX_STATS_EN.
module mesh_term_rx
  import mesh_pkg::*;
#(
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 8,
  parameter logic [3:0]  ROW_ID     = 4'd0,
  parameter logic [3:0]  COL_ID     = 4'd0,
  parameter logic [7:0]  bdcst      = {8{1'b1}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pndng,
  input  logic [pckg_sz-1:0]  data_out,
  output logic                pop,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic [pckg_sz-18:0] rx_data,
  output logic                rx_bcst,
  output logic                drop_pulse
`ifdef MESH_TERM_RX_STATS_EN
  ,
  output logic [15:0]         rx_pkt_cnt,
  output logic [15:0]         rx_drop_cnt
`endif
);
  localparam int unsigned PAY_W   = pay_w(pckg_sz);
  localparam int unsigned ENTRY_W = PAY_W + 1;

  rx_state_e          state_q, state_d;
  logic               pop_d, drop_d;
  logic               wr_en, wr_bcst, rd_en;
  logic               full, empty;
  pkt_hdr_t           hdr;
  logic [DEST_W-1:0]  dest;
  logic [ENTRY_W-1:0] rd_entry;
  logic               hdr_unused;

  assign hdr        = pkt_hdr_t'(data_out[pckg_sz-1 -: HDR_W]);
  assign dest       = {hdr.row, hdr.col};
  assign hdr_unused = ^{hdr.nxt_jmp, hdr.mode};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pop        <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      pop        <= pop_d;
      drop_pulse <= drop_d;
    end
  end

  // Head is classified on the edge that retires the pop; SETTLE covers the router's head update.
  always_comb begin
    state_d = state_q;
    pop_d   = 1'b0;
    drop_d  = 1'b0;
    wr_en   = 1'b0;
    wr_bcst = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pndng && !full) begin
          state_d = POP;
          pop_d   = 1'b1;
        end
      end
      POP: begin
        state_d = SETTLE;
        if (dest == {ROW_ID, COL_ID}) begin
          wr_en = 1'b1;
        end else if (dest == bdcst) begin
          wr_en   = 1'b1;
          wr_bcst = 1'b1;
        end else begin
          drop_d = 1'b1;
        end
      end
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  mesh_term_fifo #(
    .width (ENTRY_W),
    .depth (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data ({wr_bcst, data_out[PAY_W-1:0]}),
    .rd_en   (rd_en),
    .rd_data (rd_entry),
    .full    (full),
    .empty   (empty)
  );

  assign rd_en    = rx_valid & rx_ready;
  assign rx_valid = ~empty;
  assign rx_data  = rd_entry[PAY_W-1:0];
  assign rx_bcst  = rd_entry[PAY_W];

`ifdef MESH_TERM_RX_STATS_EN
  // Saturating accept/drop counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_pkt_cnt  <= '0;
      rx_drop_cnt <= '0;
    end else begin
      if (wr_en && rx_pkt_cnt != 16'hFFFF)   rx_pkt_cnt  <= rx_pkt_cnt + 16'd1;
      if (drop_d && rx_drop_cnt != 16'hFFFF) rx_drop_cnt <= rx_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mesh_term_rx.sv
// Self-checking bench for mesh_term_rx: in-bench router queue, rule-level
// model of pop spacing, classification and FIFO order, plus pinned literals.
module tb_mesh_term_rx;
  localparam int unsigned PSZ    = 40;
  localparam int unsigned PW     = PSZ - 17;
  localparam int          DEPTH  = 8;
  localparam logic [3:0]  MY_ROW = 4'd0;
  localparam logic [3:0]  MY_COL = 4'd1;

  logic           clk = 1'b0;
  logic           reset, pndng, rx_ready;
  logic [PSZ-1:0] data_out;
  logic           pop, rx_valid, rx_bcst, drop_pulse;
  logic [PW-1:0]  rx_data;
`ifdef MESH_TERM_RX_STATS_EN
  logic [15:0]    rx_pkt_cnt, rx_drop_cnt;
  int             exp_acc, exp_drp;
`endif

  int             errors = 0;
  int             checks = 0;
  logic [PSZ-1:0] rq[$];
  logic [PW:0]    mq[$];
  int             pop_cyc[$];
  bit             gate;
  int             rdy_mode;
  int             cyc, last_pop, n_pop, n_drop;
  bit             exp_pop, exp_drop;

  mesh_term_rx #(
    .pckg_sz    (PSZ),
    .fifo_depth (DEPTH),
    .ROW_ID     (MY_ROW),
    .COL_ID     (MY_COL),
    .bdcst      (8'hFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pndng      (pndng),
    .data_out   (data_out),
    .pop        (pop),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_bcst    (rx_bcst),
    .drop_pulse (drop_pulse)
`ifdef MESH_TERM_RX_STATS_EN
    ,
    .rx_pkt_cnt (rx_pkt_cnt),
    .rx_drop_cnt(rx_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [PSZ-1:0] mk(input logic [3:0] r, input logic [3:0] c,
                                        input logic [PW-1:0] pay);
    return {8'($urandom), r, c, 1'($urandom), pay};
  endfunction

  // One clock: compare at the falling edge, predict the next rising edge, then act as router.
  task automatic tick();
    bit         take;
    bit         do_pop;
    logic [7:0] dest;
    @(negedge clk);
    cyc++;
    take = pop & reset;
    if (pop) begin
      n_pop++;
      pop_cyc.push_back(cyc);
    end
    if (drop_pulse) n_drop++;
    if (!reset) begin
      chk("reset_pop", 32'(pop), 32'd0);
      chk("reset_valid", 32'(rx_valid), 32'd0);
      chk("reset_data", 32'(rx_data), 32'd0);
      chk("reset_bcst", 32'(rx_bcst), 32'd0);
      chk("reset_drop", 32'(drop_pulse), 32'd0);
`ifdef MESH_TERM_RX_STATS_EN
      chk("reset_pkt_cnt", 32'(rx_pkt_cnt), 32'd0);
      chk("reset_drop_cnt", 32'(rx_drop_cnt), 32'd0);
      exp_acc = 0;
      exp_drp = 0;
`endif
      mq.delete();
      last_pop = -100;
      exp_pop  = 1'b0;
      exp_drop = 1'b0;
    end else begin
      chk("pop", 32'(pop), 32'(exp_pop));
      chk("drop_pulse", 32'(drop_pulse), 32'(exp_drop));
      chk("rx_valid", 32'(rx_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("rx_data", 32'(rx_data), 32'(mq[0][PW-1:0]));
        chk("rx_bcst", 32'(rx_bcst), 32'(mq[0][PW]));
      end
`ifdef MESH_TERM_RX_STATS_EN
      chk("pkt_cnt", 32'(rx_pkt_cnt), 32'(exp_acc));
      chk("drop_cnt", 32'(rx_drop_cnt), 32'(exp_drp));
`endif
      do_pop   = pndng && (mq.size() < DEPTH) && (cyc - last_pop >= 3);
      exp_drop = 1'b0;
      if (rx_ready && mq.size() != 0) mq.delete(0);
      if (cyc - last_pop == 1) begin
        dest = data_out[PSZ-9 -: 8];
        if (dest == {MY_ROW, MY_COL}) mq.push_back({1'b0, data_out[PW-1:0]});
        else if (dest == 8'hFF)       mq.push_back({1'b1, data_out[PW-1:0]});
        else                          exp_drop = 1'b1;
`ifdef MESH_TERM_RX_STATS_EN
        if (exp_drop) begin
          if (exp_drp < 65535) exp_drp++;
        end else if (exp_acc < 65535) begin
          exp_acc++;
        end
`endif
      end
      if (do_pop) last_pop = cyc;
      exp_pop = do_pop;
    end
    @(posedge clk);
    if (take) rq.delete(0);
    #1;
    pndng    = gate && (rq.size() != 0);
    data_out = (rq.size() != 0) ? rq[0] : '0;
    rx_ready = (rdy_mode == 2) ? 1'($urandom_range(1, 0)) : (rdy_mode == 1);
  endtask

  initial begin
    int p0, d0, n, sel;
    reset    = 1'b0;
    pndng    = 1'b0;
    data_out = '0;
    rx_ready = 1'b0;
    gate     = 1'b1;
    rdy_mode = 0;
    cyc      = 0;
    last_pop = -100;
    n_pop    = 0;
    n_drop   = 0;
    exp_pop  = 1'b0;
    exp_drop = 1'b0;
`ifdef MESH_TERM_RX_STATS_EN
    exp_acc  = 0;
    exp_drp  = 0;
`endif
    repeat (3) tick();
    reset = 1'b1;

    // Single local packet: pop one cycle after pndng, payload visible the cycle after.
    rq.push_back(40'h00_0_1_0_12345);
    tick();
    chk("t1_pndng", 32'(pndng), 32'd1);
    chk("t1_no_pop_yet", 32'(pop), 32'd0);
    tick();
    chk("t1_pop", 32'(pop), 32'd1);
    tick();
    chk("t1_pop_done", 32'(pop), 32'd0);
    chk("t1_valid", 32'(rx_valid), 32'd1);
    chk("t1_data", 32'(rx_data), 32'h012345);
    chk("t1_bcst", 32'(rx_bcst), 32'd0);
    rdy_mode = 1;
    repeat (3) tick();
    chk("t1_drained", 32'(rx_valid), 32'd0);

    // Misrouted packet is popped and dropped.
    p0 = n_pop;
    d0 = n_drop;
    rq.push_back(mk(4'd2, 4'd3, 23'h55AA33));
    repeat (6) tick();
    chk("mis_pops", 32'(n_pop - p0), 32'd1);
    chk("mis_drops", 32'(n_drop - d0), 32'd1);
    chk("mis_valid", 32'(rx_valid), 32'd0);
`ifdef MESH_TERM_RX_STATS_EN
    chk("mis_drop_cnt", 32'(rx_drop_cnt), 32'd1);
`endif

    // Broadcast packet lands with the bcst flag.
    rdy_mode = 0;
    rq.push_back(mk(4'hF, 4'hF, 23'h7ABCDE));
    repeat (4) tick();
    chk("bc_valid", 32'(rx_valid), 32'd1);
    chk("bc_data", 32'(rx_data), 32'h7ABCDE);
    chk("bc_bcst", 32'(rx_bcst), 32'd1);
    rdy_mode = 1;
    repeat (3) tick();

    // Backpressure: 8 pops fill the FIFO, the rest wait until the host drains.
    rdy_mode = 0;
    tick();
    p0 = n_pop;
    for (int i = 0; i < 10; i++) rq.push_back(mk(MY_ROW, MY_COL, 23'(i * 4097 + 5)));
    repeat (40) tick();
    chk("bp_pops_full", 32'(n_pop - p0), 32'd8);
    chk("bp_pndng_held", 32'(pndng), 32'd1);
    chk("bp_router_left", 32'(rq.size()), 32'd2);
    rdy_mode = 1;
    repeat (60) tick();
    chk("bp_pops_total", 32'(n_pop - p0), 32'd10);
    chk("bp_empty", 32'(rx_valid), 32'd0);
    chk("bp_router_empty", 32'(rq.size()), 32'd0);

    // Back-to-back: pop pulses exactly three cycles apart.
    pop_cyc.delete();
    for (int i = 0; i < 4; i++) rq.push_back(mk(MY_ROW, MY_COL, 23'(32'h100 + i)));
    repeat (20) tick();
    chk("b2b_count", 32'(pop_cyc.size()), 32'd4);
    for (int i = 1; i < 4 && i < pop_cyc.size(); i++)
      chk("b2b_spacing", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd3);

    // Reset while in POP: outputs clear at once, FIFO empty afterwards.
    rdy_mode = 0;
    rq.push_back(mk(MY_ROW, MY_COL, 23'h0BEEF1));
    repeat (5) tick();
    chk("rp_prefill", 32'(rx_valid), 32'd1);
    rq.push_back(mk(MY_ROW, MY_COL, 23'h0BEEF2));
    n = 0;
    while (!pop && n < 10) begin
      tick();
      n++;
    end
    chk("rp_reached_pop", 32'(pop), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rp_pop_async", 32'(pop), 32'd0);
    chk("rp_valid_async", 32'(rx_valid), 32'd0);
    chk("rp_data_async", 32'(rx_data), 32'd0);
    chk("rp_drop_async", 32'(drop_pulse), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    chk("rp_fifo_empty", 32'(rx_valid), 32'd0);
    chk("rp_not_consumed", 32'(rq.size()), 32'd1);
    rdy_mode = 1;
    repeat (8) tick();
    chk("rp_reissued", 32'(rq.size()), 32'd0);

    // Randomized traffic against the model.
    rdy_mode = 2;
    repeat (400) begin
      if (rq.size() < 4 && $urandom_range(2, 0) == 0) begin
        sel = int'($urandom_range(3, 0));
        if (sel < 2)       rq.push_back(mk(MY_ROW, MY_COL, 23'($urandom)));
        else if (sel == 2) rq.push_back(mk(4'hF, 4'hF, 23'($urandom)));
        else               rq.push_back(mk(4'($urandom), 4'($urandom), 23'($urandom)));
      end
      gate = ($urandom_range(7, 0) != 0);
      tick();
    end
    gate     = 1'b1;
    rdy_mode = 1;
    repeat (60) tick();
    chk("rnd_router_empty", 32'(rq.size()), 32'd0);
    chk("rnd_fifo_empty", 32'(rx_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
